cell_revealer: RTL and testbench
================================

CELL_REVEALER -- requirements
Module: cell_revealer

Interface
REQ-001 SHALL have parameters: MAX_CELL_WIDTH, default 30, max columns; MAX_CELL_HEIGHT, default 16, max rows; CELL_COUNT = MAX_CELL_WIDTH*MAX_CELL_HEIGHT (derived).
REQ-002 SHALL have derived widths: CELL_X_WIDTH = $clog2(MAX_CELL_WIDTH); CELL_Y_WIDTH = $clog2(MAX_CELL_HEIGHT); CNT_WIDTH = $clog2(CELL_COUNT+1); MINES_WIDTH = $clog2(CELL_COUNT/4).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 clock, all state on rising edge; rst input 1 async active-low reset.
REQ-004 SHALL have the following data ports:
- game_field_i, input, [3:0] array [MAX_CELL_WIDTH][MAX_CELL_HEIGHT], indexed [x][y]: 0..8 is neighbour mine count, 9 is mine. Held stable by the producer while this block is in use.
- field_width_i, input, CELL_X_WIDTH: active columns.
- field_height_i, input, CELL_Y_WIDTH: active rows.
- mines_count_i, input, MINES_WIDTH: mines placed.
- open_valid_i, input, 1: open request.
- open_x_i, input, CELL_X_WIDTH: request column.
- open_y_i, input, CELL_Y_WIDTH: request row.
- open_ready_o, output, 1: request accepted when open_valid_i && open_ready_o.
- clear_i, input, 1: new-game clear.
- revealed_o, output, 1-bit array [MAX_CELL_WIDTH][MAX_CELL_HEIGHT]: cell revealed.
- revealed_count_o, output, CNT_WIDTH: number of revealed cells.
- mine_hit_o, output, 1: sticky, a mine was opened.
- win_o, output, 1: all non-mine cells revealed.
- done_o, output, 1: one-cycle pulse at request completion.

Function
REQ-005 SHALL implement FSM states IDLE, CHECK, POP, EXPAND, DONE; open_ready_o = (state == IDLE) && !clear_i.
REQ-006 SHALL, in IDLE with clear_i=1, clear all revealed_o bits, revealed_count_o and mine_hit_o next edge; clear_i has priority over open_valid_i.
REQ-007 SHALL, on accept, latch open_x_i/open_y_i, field_width_i and field_height_i, then go to CHECK.
REQ-008 SHALL, in CHECK:
- cell out of bounds (x >= width or y >= height) or already revealed: go to DONE, no change.
- value 9: reveal it, set mine_hit_o, go to DONE.
- value 1..8: reveal it, go to DONE.
- value 0: reveal it, push it to the coordinate FIFO, go to POP.
REQ-009 SHALL implement the coordinate FIFO with depth CELL_COUNT, storing {x,y}, one push and/or one pop per cycle.
REQ-010 SHALL, in POP: FIFO empty -> DONE; else pop into the current cell, reset neighbour index to 0, go to EXPAND.
REQ-011 SHALL, in EXPAND, examine one neighbour per cycle in order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
- A neighbour is eligible if in bounds (no wrap-around: x-1 at x=0 and x+1 at x=width-1 are out), not revealed, and not 9.
- An eligible neighbour is revealed that cycle.
- An eligible neighbour of value 0 is also pushed.
- After index 7, go to POP.
REQ-012 SHALL reveal every cell at most once; pushes only accompany reveals, so the FIFO can never overflow and no overflow handling exists.
REQ-013 SHALL increment revealed_count_o by 1 in the same edge as each reveal.
REQ-014 SHALL use combinational win_o = (revealed_count_o == width_latched*height_latched - mines_count_i) && !mine_hit_o.
REQ-015 SHALL assert done_o exactly one cycle in DONE, then return to IDLE.
REQ-016 SHALL take 2 busy cycles for a non-zero or invalid open, and 3 + 9*P busy cycles for a zero open, P = cells pushed.
REQ-017 SHALL ignore open_valid_i and clear_i while not in IDLE; the requester holds its request until accepted.

Reset
REQ-018 SHALL, on rst=0 (asynchronous), force: state IDLE, FIFO empty, revealed_o all 0, revealed_count_o 0, mine_hit_o 0, done_o 0, open_ready_o 1 after reset release.
REQ-019 SHALL, on reset mid-flood, abort immediately with no partial state retained.

Verification
REQ-020 SHALL verify: 4x4 field, one mine at (3,3), mines=1, open (0,0) -> 15 revealed, (3,3) unrevealed, P=12, busy 111 cycles, done_o one pulse, win_o=1.
REQ-021 SHALL verify: same field, open (3,3) -> busy 2 cycles, mine_hit_o=1, revealed_count_o=1, win_o=0; mine_hit_o stays 1 until clear_i.
REQ-022 SHALL verify: open (2,2) (value 1) -> only (2,2) revealed, count=1, busy 2 cycles; reopen (2,2) -> count unchanged, done_o still pulses.
REQ-023 SHALL verify: open (5,0) on a 4-wide field -> no reveal, done_o after 2 busy cycles.
REQ-024 SHALL verify: 30x15 all-zero field, mines=0, open (29,14) -> count 450, no duplicate reveals, no wrap at edges, win_o=1.
REQ-025 SHALL verify: rst=0 asserted during EXPAND -> all outputs 0 that cycle; clear_i with open_valid_i in IDLE -> clear wins, request not accepted that cycle.

Source files
------------

// File: rtl/cell_revealer.sv
// Minesweeper cell revealer: opens one cell per request and flood-fills
// zero regions breadth-first through a coordinate FIFO.
module cell_revealer #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16,
  parameter int CELL_COUNT      = MAX_CELL_WIDTH * MAX_CELL_HEIGHT,
  parameter int CELL_X_WIDTH    = $clog2(MAX_CELL_WIDTH),
  parameter int CELL_Y_WIDTH    = $clog2(MAX_CELL_HEIGHT),
  parameter int CNT_WIDTH       = $clog2(CELL_COUNT + 1),
  parameter int MINES_WIDTH     = $clog2(CELL_COUNT / 4)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              game_field_i [MAX_CELL_WIDTH][MAX_CELL_HEIGHT],
  input  logic [CELL_X_WIDTH-1:0] field_width_i,
  input  logic [CELL_Y_WIDTH-1:0] field_height_i,
  input  logic [MINES_WIDTH-1:0]  mines_count_i,
  input  logic                    open_valid_i,
  input  logic [CELL_X_WIDTH-1:0] open_x_i,
  input  logic [CELL_Y_WIDTH-1:0] open_y_i,
  output logic                    open_ready_o,
  input  logic                    clear_i,
  output logic                    revealed_o [MAX_CELL_WIDTH][MAX_CELL_HEIGHT],
  output logic [CNT_WIDTH-1:0]    revealed_count_o,
  output logic                    mine_hit_o,
  output logic                    win_o,
  output logic                    done_o
);

  localparam int PTR_WIDTH = $clog2(CELL_COUNT);
  localparam int FW        = CELL_X_WIDTH + CELL_Y_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    POP,
    EXPAND,
    DONE
  } state_t;

  state_t state;

  logic [CELL_X_WIDTH-1:0] cur_x;
  logic [CELL_Y_WIDTH-1:0] cur_y;
  logic [CELL_X_WIDTH-1:0] w_l;
  logic [CELL_Y_WIDTH-1:0] h_l;
  logic [2:0]              nbr_idx;

  logic [FW-1:0]        fifo_mem [CELL_COUNT];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] fifo_cnt;

  logic                    cur_in;
  logic                    cur_rev;
  logic [3:0]              cur_val;
  logic                    x_dec;
  logic                    x_inc;
  logic                    y_dec;
  logic                    y_inc;
  logic [CELL_X_WIDTH-1:0] nx;
  logic [CELL_Y_WIDTH-1:0] ny;
  logic                    nb_in;
  logic                    nb_rev;
  logic [3:0]              nb_val;
  logic                    nb_ok;
  logic                    push;
  logic                    pop;
  logic [FW-1:0]           push_data;
  logic [FW-1:0]           pop_data;
  logic [CNT_WIDTH-1:0]    target;

  function automatic logic [PTR_WIDTH-1:0] ptr_inc(
    input logic [PTR_WIDTH-1:0] p
  );
    return (p == PTR_WIDTH'(CELL_COUNT - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    cur_in  = (cur_x < w_l) && (cur_y < h_l);
    cur_rev = revealed_o[cur_x][cur_y];
    cur_val = game_field_i[cur_x][cur_y];
  end

  always_comb begin
    x_dec = 1'b0;
    x_inc = 1'b0;
    y_dec = 1'b0;
    y_inc = 1'b0;
    unique case (nbr_idx)
      3'd0: begin x_dec = 1'b1; y_dec = 1'b1; end
      3'd1: y_dec = 1'b1;
      3'd2: begin x_inc = 1'b1; y_dec = 1'b1; end
      3'd3: x_dec = 1'b1;
      3'd4: x_inc = 1'b1;
      3'd5: begin x_dec = 1'b1; y_inc = 1'b1; end
      3'd6: y_inc = 1'b1;
      default: begin x_inc = 1'b1; y_inc = 1'b1; end
    endcase
    nx = cur_x - CELL_X_WIDTH'(x_dec) + CELL_X_WIDTH'(x_inc);
    ny = cur_y - CELL_Y_WIDTH'(y_dec) + CELL_Y_WIDTH'(y_inc);
    // Edge guards stop x-1 at column 0 from wrapping into a valid column.
    nb_in = (nx < w_l) && (ny < h_l)
          && !(x_dec && cur_x == '0)
          && !(y_dec && cur_y == '0);
    nb_rev = revealed_o[nx][ny];
    nb_val = game_field_i[nx][ny];
    nb_ok  = nb_in && !nb_rev && (nb_val != 4'd9);
  end

  always_comb begin
    push = ((state == CHECK) && cur_in && !cur_rev && (cur_val == 4'd0))
        || ((state == EXPAND) && nb_ok && (nb_val == 4'd0));
    push_data = (state == CHECK) ? {cur_x, cur_y} : {nx, ny};
    pop       = (state == POP) && (fifo_cnt != '0);
    pop_data  = fifo_mem[rd_ptr];
    target    = CNT_WIDTH'(w_l) * CNT_WIDTH'(h_l)
              - CNT_WIDTH'(mines_count_i);
  end

  assign open_ready_o = rst && (state == IDLE) && !clear_i;
  assign win_o = rst && (revealed_count_o == target) && !mine_hit_o;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cur_x            <= '0;
      cur_y            <= '0;
      w_l              <= '0;
      h_l              <= '0;
      nbr_idx          <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_cnt         <= '0;
      revealed_count_o <= '0;
      mine_hit_o       <= 1'b0;
      done_o           <= 1'b0;
      for (int x = 0; x < MAX_CELL_WIDTH; x++)
        for (int y = 0; y < MAX_CELL_HEIGHT; y++)
          revealed_o[x][y] <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      unique case (state)
        IDLE: begin
          if (clear_i) begin
            revealed_count_o <= '0;
            mine_hit_o       <= 1'b0;
            for (int x = 0; x < MAX_CELL_WIDTH; x++)
              for (int y = 0; y < MAX_CELL_HEIGHT; y++)
                revealed_o[x][y] <= 1'b0;
          end else if (open_valid_i) begin
            cur_x <= open_x_i;
            cur_y <= open_y_i;
            w_l   <= field_width_i;
            h_l   <= field_height_i;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!cur_in || cur_rev) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            revealed_o[cur_x][cur_y] <= 1'b1;
            revealed_count_o <= revealed_count_o + 1'b1;
            if (cur_val == 4'd9) mine_hit_o <= 1'b1;
            if (cur_val == 4'd0) begin
              state <= POP;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
            end
          end
        end
        POP: begin
          if (fifo_cnt == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            {cur_x, cur_y} <= pop_data;
            nbr_idx        <= '0;
            state          <= EXPAND;
          end
        end
        EXPAND: begin
          if (nb_ok) begin
            revealed_o[nx][ny] <= 1'b1;
            revealed_count_o   <= revealed_count_o + 1'b1;
          end
          nbr_idx <= nbr_idx + 1'b1;
          if (nbr_idx == 3'd7) state <= POP;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_revealer.sv
// Scoreboard bench for cell_revealer: a fixpoint flood model predicts
// reveal map, count, mine/win flags and busy cycles per open request.
module tb_cell_revealer;
  localparam int W = 30;
  localparam int H = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] field [W][H];
  logic [4:0] fw;
  logic [3:0] fh;
  logic [6:0] mines;
  logic       ov;
  logic [4:0] ox;
  logic [3:0] oy;
  logic       ordy;
  logic       clr;
  logic       rev [W][H];
  logic [8:0] rcnt;
  logic       mhit;
  logic       win;
  logic       done;

  always #5 clk = ~clk;

  cell_revealer dut (
    .clk              (clk),
    .rst              (rst),
    .game_field_i     (field),
    .field_width_i    (fw),
    .field_height_i   (fh),
    .mines_count_i    (mines),
    .open_valid_i     (ov),
    .open_x_i         (ox),
    .open_y_i         (oy),
    .open_ready_o     (ordy),
    .clear_i          (clr),
    .revealed_o       (rev),
    .revealed_count_o (rcnt),
    .mine_hit_o       (mhit),
    .win_o            (win),
    .done_o           (done)
  );

  typedef struct {
    int count;
    int mine;
    int win;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mine_map [W][H];
  bit   exp_rev [W][H];
  int   exp_cnt;
  bit   exp_mine;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int map_diff();
    int n = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        if (rev[x][y] !== exp_rev[x][y]) n++;
    return n;
  endfunction

  function automatic int rev_ones();
    int n = 0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        if (rev[x][y] !== 1'b0) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        exp_rev[x][y] = 1'b0;
    exp_cnt  = 0;
    exp_mine = 1'b0;
  endtask

  task automatic build_field(input int w, input int h);
    fw = 5'(w);
    fh = 4'(h);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++) begin
        int n = 0;
        for (int dx = -1; dx <= 1; dx++)
          for (int dy = -1; dy <= 1; dy++) begin
            int px = x + dx;
            int py = y + dy;
            if (px >= 0 && px < w && py >= 0 && py < h)
              if (mine_map[px][py]) n++;
          end
        field[x][y] = mine_map[x][y] ? 4'd9 : 4'(n);
      end
  endtask

  task automatic model_open(input int x, input int y, output int busy);
    bit fresh [W][H];
    bit changed;
    int p = 0;
    busy = 2;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < H; j++)
        fresh[i][j] = 1'b0;
    if (x < int'(fw) && y < int'(fh)) begin
      if (!exp_rev[x][y]) begin
        exp_rev[x][y] = 1'b1;
        exp_cnt++;
        if (field[x][y] == 4'd9) exp_mine = 1'b1;
        if (field[x][y] == 4'd0) begin
          fresh[x][y] = 1'b1;
          do begin
            changed = 1'b0;
            for (int cx = 0; cx < int'(fw); cx++)
              for (int cy = 0; cy < int'(fh); cy++)
                if (fresh[cx][cy] && field[cx][cy] == 4'd0)
                  for (int dx = -1; dx <= 1; dx++)
                    for (int dy = -1; dy <= 1; dy++) begin
                      int px = cx + dx;
                      int py = cy + dy;
                      if (px >= 0 && px < int'(fw) && py >= 0 && py < int'(fh))
                        if (!exp_rev[px][py] && field[px][py] != 4'd9) begin
                          exp_rev[px][py] = 1'b1;
                          fresh[px][py]   = 1'b1;
                          exp_cnt++;
                          changed = 1'b1;
                        end
                    end
          end while (changed);
          for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
              if (fresh[i][j] && field[i][j] == 4'd0) p++;
          busy = 3 + 9 * p;
        end
      end
    end
  endtask

  task automatic do_open(input string tag, input int x, input int y);
    exp_t e;
    int   ebusy;
    int   busy   = 0;
    int   pulses = 0;
    int   cyc    = 0;
    model_open(x, y, ebusy);
    e.count = exp_cnt;
    e.mine  = int'(exp_mine);
    e.win   = int'(exp_cnt == int'(fw) * int'(fh) - int'(mines) && !exp_mine);
    sb.push_back(e);
    ov = 1'b1;
    ox = 5'(x);
    oy = 4'(y);
    @(posedge clk);
    #1;
    ov = 1'b0;
    while (!ordy && cyc < 6000) begin
      busy++;
      if (done) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, "_count"}, int'(rcnt), e.count);
          chk({tag, "_mine"}, int'(mhit), e.mine);
          chk({tag, "_win"}, int'(win), e.win);
          chk({tag, "_map"}, map_diff(), 0);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!ordy) chk({tag, "_timeout"}, 1, 0);
    chk({tag, "_busy"}, busy, ebusy);
    chk({tag, "_pulses"}, pulses, 1);
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    model_reset();
    chk("clear_count", int'(rcnt), 0);
    chk("clear_mine", int'(mhit), 0);
    chk("clear_map", rev_ones(), 0);
  endtask

  initial begin
    ov    = 1'b0;
    ox    = '0;
    oy    = '0;
    clr   = 1'b0;
    mines = '0;
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        mine_map[x][y] = 1'b0;
    mine_map[3][3] = 1'b1;
    build_field(4, 4);
    mines = 7'd1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_count", int'(rcnt), 0);
    chk("rst_mine", int'(mhit), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(ordy), 1);
    chk("rst_map", rev_ones(), 0);

    do_open("flood00", 0, 0);
    chk("flood00_corner", int'(rev[3][3]), 0);

    do_clear();
    do_open("mine33", 3, 3);
    do_open("after_mine", 0, 0);
    chk("mine_sticky", int'(mhit), 1);
    do_clear();

    do_open("num22", 2, 2);
    do_open("reopen22", 2, 2);
    do_open("oob50", 5, 0);

    clr = 1'b1;
    ov  = 1'b1;
    ox  = '0;
    oy  = '0;
    #1;
    chk("clr_ready_low", int'(ordy), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    ov  = 1'b0;
    #1;
    model_reset();
    chk("clr_wins_count", int'(rcnt), 0);
    chk("clr_wins_idle", int'(ordy), 1);

    mine_map[3][3] = 1'b0;
    mines = '0;
    build_field(30, 15);
    ov = 1'b1;
    ox = '0;
    oy = '0;
    @(posedge clk);
    #1;
    ov = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", int'(ordy), 0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_count", int'(rcnt), 0);
    chk("midrst_mine", int'(mhit), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_win", int'(win), 0);
    chk("midrst_ready", int'(ordy), 0);
    chk("midrst_map", rev_ones(), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("postrst_ready", int'(ordy), 1);
    chk("postrst_count", int'(rcnt), 0);

    do_open("full", 29, 14);
    chk("full_count450", int'(rcnt), 450);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
